// File: rtl/mod_74x08_bist.sv
// mod_74x08_bist: exhaustive truth-table BIST sequencer for one 74x08
// (quad 2-input AND). Walks 16 steps (4 gates x 4 vectors), samples Y
// after a programmable settle time, reports sticky per-output failures.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_clr_n      asynchronous active-low reset
//   i_start      run request, honoured in IDLE or FINISH only
//   o_a, o_b     gate inputs driven to the 74x08 (bit n -> gate n+1)
//   i_y          gate outputs from the 74x08 (bit n <- gate n+1)
//   o_busy       walk in progress (APPLY/SETTLE/CHECK)
//   o_done       walk finished, held until next START or reset
//   o_pass       no mismatch seen; valid while o_done
//   o_fail_mask  sticky per-output mismatch flags
//   o_fail_step  step index of the first mismatch
module mod_74x08_bist #(
    parameter int unsigned SETTLE = 4
) (
    input  logic       i_clk,
    input  logic       i_clr_n,
    input  logic       i_start,
    output logic [3:0] o_a,
    output logic [3:0] o_b,
    input  logic [3:0] i_y,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [3:0] o_fail_mask,
    output logic [3:0] o_fail_step
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CHECK,
        S_FINISH
    } state_t;

    localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

    state_t     r_state, w_state;
    logic [3:0] r_step, w_step;
    logic [7:0] r_cnt, w_cnt;
    logic [3:0] r_a, w_a;
    logic [3:0] r_b, w_b;
    logic       r_busy, w_busy;
    logic       r_done, w_done;
    logic       r_pass, w_pass;
    logic [3:0] r_mask, w_mask;
    logic [3:0] r_fstep, w_fstep;

    logic [3:0] w_exp;
    logic [3:0] w_mism;
    logic [3:0] w_mask_upd;
    logic [3:0] w_step_inc;

    // Vector map: v0=(1,1) v1=(0,1) v2=(1,0) v3=(0,0), so A is the
    // inverse of v[0] and B the inverse of v[1] on the selected gate.
    function automatic logic [3:0] vec_a(input logic [3:0] s);
        return s[0] ? 4'b0000 : (4'b0001 << s[3:2]);
    endfunction

    function automatic logic [3:0] vec_b(input logic [3:0] s);
        return s[1] ? 4'b0000 : (4'b0001 << s[3:2]);
    endfunction

    assign w_step_inc = r_step + 4'd1;
    assign w_mask_upd = r_mask | w_mism;

    // Only the selected gate under v0 may be high; every other output
    // must stay low, which also catches bridges between gates.
    always_comb begin
        w_exp = 4'b0000;
        if (r_step[1:0] == 2'd0) begin
            w_exp = 4'b0001 << r_step[3:2];
        end
    end

    // Case inequality so that X/Z on Y is reported as a mismatch.
    always_comb begin
        w_mism = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            w_mism[n] = (i_y[n] !== w_exp[n]);
        end
    end

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_state <= S_IDLE;
            r_step  <= 4'd0;
            r_cnt   <= 8'd0;
            r_a     <= 4'd0;
            r_b     <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_mask  <= 4'd0;
            r_fstep <= 4'd0;
        end else begin
            r_state <= w_state;
            r_step  <= w_step;
            r_cnt   <= w_cnt;
            r_a     <= w_a;
            r_b     <= w_b;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_pass  <= w_pass;
            r_mask  <= w_mask;
            r_fstep <= w_fstep;
        end
    end

    always_comb begin
        w_state = r_state;
        w_step  = r_step;
        w_cnt   = r_cnt;
        w_a     = r_a;
        w_b     = r_b;
        w_busy  = r_busy;
        w_done  = r_done;
        w_pass  = r_pass;
        w_mask  = r_mask;
        w_fstep = r_fstep;
        unique case (r_state)
            S_IDLE, S_FINISH: begin
                if (i_start) begin
                    w_state = S_APPLY;
                    w_step  = 4'd0;
                    w_mask  = 4'd0;
                    w_fstep = 4'd0;
                    w_done  = 1'b0;
                    w_pass  = 1'b0;
                    w_busy  = 1'b1;
                    w_a     = vec_a(4'd0);
                    w_b     = vec_b(4'd0);
                end
            end
            S_APPLY: begin
                w_cnt = SETTLE_CNT;
                if (SETTLE_CNT != 8'd0) begin
                    w_state = S_SETTLE;
                end else begin
                    w_state = S_CHECK;
                end
            end
            S_SETTLE: begin
                // Counter holds the cycles still to spend here,
                // including the current one.
                w_cnt = r_cnt - 8'd1;
                if (r_cnt <= 8'd1) begin
                    w_state = S_CHECK;
                end
            end
            S_CHECK: begin
                w_mask = w_mask_upd;
                if ((r_mask == 4'd0) && (w_mism != 4'd0)) begin
                    w_fstep = r_step;
                end
                if (r_step == 4'd15) begin
                    w_state = S_FINISH;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_pass  = (w_mask_upd == 4'd0);
                    w_a     = 4'd0;
                    w_b     = 4'd0;
                end else begin
                    w_state = S_APPLY;
                    w_step  = w_step_inc;
                    w_a     = vec_a(w_step_inc);
                    w_b     = vec_b(w_step_inc);
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign o_a         = r_a;
    assign o_b         = r_b;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_fail_mask = r_mask;
    assign o_fail_step = r_fstep;

endmodule

// File: tb/tb_mod_74x08_bist.sv
// tb_mod_74x08_bist: drives two BIST instances (SETTLE=4 and SETTLE=8)
// against a configurable faulty 74x08 model and a walk-level reference.
module tb_mod_74x08_bist;

    logic            clk = 1'b0;
    logic            clr_n;
    logic [1:0]      start;
    logic [1:0][3:0] a, b, y, fmask, fstep;
    logic [1:0]      busy, done, pass;
    logic [1:0][3:0] sa1, sa0, orm;
    int              dly [2];
    logic [1:0][7:0][3:0] pipe;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mod_74x08_bist #(.SETTLE(4)) u_dut4 (
        .i_clk(clk), .i_clr_n(clr_n), .i_start(start[0]),
        .o_a(a[0]), .o_b(b[0]), .i_y(y[0]),
        .o_busy(busy[0]), .o_done(done[0]), .o_pass(pass[0]),
        .o_fail_mask(fmask[0]), .o_fail_step(fstep[0])
    );

    mod_74x08_bist #(.SETTLE(8)) u_dut8 (
        .i_clk(clk), .i_clr_n(clr_n), .i_start(start[1]),
        .o_a(a[1]), .o_b(b[1]), .i_y(y[1]),
        .o_busy(busy[1]), .o_done(done[1]), .o_pass(pass[1]),
        .o_fail_mask(fmask[1]), .o_fail_step(fstep[1])
    );

    // Faulty chip: OR-substituted gates, stuck-at-0/1 outputs.
    function automatic logic [3:0] chip(input logic [3:0] av, bv,
                                        s1, s0, om);
        return ((((av & bv) & ~om) | ((av | bv) & om)) & ~s0) | s1;
    endfunction

    // Registered chip output followed by a variable-length delay line.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            pipe[k][0] <= chip(a[k], b[k], sa1[k], sa0[k], orm[k]);
            for (int j = 1; j < 8; j++) pipe[k][j] <= pipe[k][j-1];
        end
    end

    always_comb begin
        y = '0;
        for (int k = 0; k < 2; k++) y[k] = pipe[k][dly[k]-1];
    end

    function automatic int settle_of(input int k);
        return (k != 0) ? 8 : 4;
    endfunction

    // Step s tests gate s/4 with vector s%4: (1,1),(0,1),(1,0),(0,0).
    function automatic logic [7:0] vec_ab(input int s);
        logic [3:0] av, bv;
        int g, v;
        g = s / 4;
        v = s % 4;
        av = 4'd0;
        bv = 4'd0;
        if (v == 0 || v == 2) av = 4'(1 << g);
        if (v == 0 || v == 1) bv = 4'(1 << g);
        return {av, bv};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Timeline model: step s occupies cycles s*P..s*P+P-1 after edge 0;
    // Y sampled at edge (s+1)*P reflects A/B present 1+dly cycles before.
    task automatic model(input int k, output logic [3:0] m,
                         output logic [3:0] st);
        int P, t;
        logic [7:0] ab;
        logic [3:0] yv, e, mm;
        P  = settle_of(k) + 2;
        m  = 4'd0;
        st = 4'd0;
        for (int s = 0; s < 16; s++) begin
            t  = (s + 1) * P - 1 - dly[k];
            ab = (t >= 0) ? vec_ab(t / P) : 8'd0;
            yv = chip(ab[7:4], ab[3:0], sa1[k], sa0[k], orm[k]);
            e  = (s % 4 == 0) ? 4'(1 << (s / 4)) : 4'd0;
            mm = yv ^ e;
            if (mm != 4'd0 && m == 4'd0) st = 4'(s);
            m  = m | mm;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run(input int k, input bit noise);
        int P, nb, cyc;
        logic [3:0] em, es;
        P   = settle_of(k) + 2;
        nb  = 0;
        cyc = 0;
        @(negedge clk);
        start[k] = 1'b1;
        @(negedge clk);
        chk("busy_rise", busy[k], 1);
        chk("done_clr", done[k], 0);
        chk("mask_clr", fmask[k], 0);
        chk("fstep_clr", fstep[k], 0);
        start[k] = 1'b0;
        while (!done[k] && cyc < 16 * P + 10) begin
            if (busy[k]) nb++;
            if (cyc % P == 0 && cyc < 16 * P)
                chk($sformatf("ab_step%0d", cyc / P),
                    {a[k], b[k]}, vec_ab(cyc / P));
            start[k] = (noise && cyc < 16 * P - 2) ?
                       1'($urandom % 2) : 1'b0;
            @(negedge clk);
            cyc++;
        end
        start[k] = 1'b0;
        model(k, em, es);
        chk("done_timeout", done[k], 1);
        chk("busy_cycles", nb, 16 * P);
        chk("busy_fall", busy[k], 0);
        chk("fail_mask", fmask[k], em);
        chk("pass", pass[k], (em == 4'd0));
        if (em != 4'd0) chk("fail_step", fstep[k], es);
        chk("ab_finish", {a[k], b[k]}, 0);
    endtask

    initial begin
        int k;
        clr_n  = 1'b0;
        start  = '0;
        sa1    = '0;
        sa0    = '0;
        orm    = '0;
        dly[0] = 1;
        dly[1] = 1;
        idle(10);
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", busy[i], 0);
            chk("rst_done", done[i], 0);
            chk("rst_pass", pass[i], 0);
            chk("rst_mask", fmask[i], 0);
            chk("rst_fstep", fstep[i], 0);
            chk("rst_ab", {a[i], b[i]}, 0);
        end
        clr_n = 1'b1;
        idle(3);

        run(0, 0);
        chk("good_pass", pass[0], 1);
        chk("good_mask", fmask[0], 4'b0000);

        sa1[0] = 4'b0100;
        idle(10);
        run(0, 0);
        chk("sa1_mask", fmask[0], 4'b0100);
        chk("sa1_step", fstep[0], 0);
        chk("sa1_pass", pass[0], 0);
        sa1[0] = 4'b0000;
        idle(10);

        orm[0] = 4'b0010;
        idle(10);
        run(0, 0);
        chk("or_mask", fmask[0], 4'b0010);
        chk("or_step", fstep[0], 5);
        orm[0] = 4'b0000;
        run(0, 0);
        chk("rerun_pass", pass[0], 1);

        dly[0] = 6;
        dly[1] = 6;
        idle(10);
        run(0, 0);
        chk("dly6_s4_pass", pass[0], 0);
        chk("dly6_s4_step", fstep[0], 0);
        run(1, 0);
        chk("dly6_s8_pass", pass[1], 1);
        dly[0] = 1;
        dly[1] = 1;
        idle(10);

        orm[0] = 4'b0010;
        idle(10);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        idle(40);
        chk("mid_busy", busy[0], 1);
        chk("mid_mask", fmask[0], 4'b0010);
        clr_n = 1'b0;
        #1;
        chk("abort_busy", busy[0], 0);
        chk("abort_done", done[0], 0);
        chk("abort_ab", {a[0], b[0]}, 0);
        chk("abort_mask", fmask[0], 0);
        chk("abort_fstep", fstep[0], 0);
        @(negedge clk);
        clr_n  = 1'b1;
        orm[0] = 4'b0000;
        idle(10);
        run(0, 0);
        chk("after_abort_pass", pass[0], 1);

        run(0, 1);
        run(1, 1);

        repeat (10) begin
            k = int'($urandom % 2);
            sa1[k] = ($urandom % 3 == 0) ?
                     4'(1 << $urandom_range(0, 3)) : 4'd0;
            sa0[k] = ($urandom % 3 == 0) ?
                     4'(1 << $urandom_range(0, 3)) : 4'd0;
            orm[k] = ($urandom % 3 == 0) ?
                     4'($urandom_range(0, 15)) : 4'd0;
            dly[k] = $urandom_range(1, 8);
            idle(10);
            run(k, 1'($urandom % 2));
            sa1[k] = 4'd0;
            sa0[k] = 4'd0;
            orm[k] = 4'd0;
            dly[k] = 1;
            idle(10);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mod_74x08_bist.md
# mod_74x08_bist

Built-in self-test sequencer for the quad 2-input AND package (74x08). It drives all eight gate inputs through an exhaustive per-gate truth-table walk and samples the four outputs after a programmable settle time. It then reports per-output pass/fail and the first failing step. It sits between board-level test control and a single 74x08 instance, and owns that instance's inputs while running.

## Interface
- SETTLE, 4: wait cycles between applying a vector and sampling Y. Range 0..255.
- CLK  in  1  system clock; all state changes on the rising edge.
- CLR_n  in  1  asynchronous, active-low reset.
- START  in  1  run request. Sampled only in IDLE or FINISH.
- A  out  4  gate A inputs to the DUT. Bit n drives gate n+1.
- B  out  4  gate B inputs to the DUT. Bit n drives gate n+1.
- Y  in  4  gate outputs from the DUT. Bit n comes from gate n+1.
- BUSY  out  1  high while a test walk is in progress.
- DONE  out  1  high from the end of a walk until the next START or reset.
- PASS  out  1  valid when DONE is high; 1 means no mismatch was seen.
- FAIL_MASK  out  4  sticky; bit n is set if Y[n] ever mismatched.
- FAIL_STEP  out  4  step index of the first mismatch. Valid when FAIL_MASK != 0.

## Operation
- Reset (CLR_n low, asynchronous) forces:
  - state = IDLE
  - A = B = 0
  - BUSY = DONE = PASS = 0
  - FAIL_MASK = 0, FAIL_STEP = 0, step counter = 0, settle counter = 0
- Reset mid-walk aborts the walk immediately, with no partial results retained.
- Step index is 4 bits: gate g = step[3:2], vector v = step[1:0]. Steps run 0..15 in order.
- Vector map (A,B): v0 = (1,1), v1 = (0,1), v2 = (1,0), v3 = (0,0).
- During step s:
  - A[g] and B[g] carry the vector.
  - All non-selected gates are driven A = B = 0.
- Expected Y for step s:
  - Y[g] = 1 only for v0, else 0.
  - All other Y bits = 0. This detects bridging faults between gates.
- Mismatch rule:
  - Any Y bit not equal to its expected value sets FAIL_MASK of that bit. X or Z counts as a mismatch.
  - FAIL_STEP loads s only when FAIL_MASK was 0 before this check.
- States:
  - IDLE: START=1 → APPLY. Entering APPLY from IDLE or FINISH clears FAIL_MASK, FAIL_STEP, DONE, PASS and sets step = 0.
  - APPLY: registers A/B for the current step and loads the settle counter with SETTLE. Goes to SETTLE if SETTLE > 0, else CHECK.
  - SETTLE: decrements the counter; at 0 → CHECK.
  - CHECK: compares Y and updates the fail fields. If step = 15 → FINISH, else step+1 → APPLY.
  - FINISH: A = B = 0, DONE = 1, PASS = (FAIL_MASK == 0). START=1 → APPLY.
- BUSY = 1 in APPLY, SETTLE and CHECK.
- START while BUSY is ignored. START held high continuously causes back-to-back walks, each separated by one FINISH cycle.

## Timing
- All outputs are registered.
- A/B for a step change on the edge entering APPLY. They hold until the next APPLY edge, or until FINISH.
- Each step takes exactly SETTLE + 2 cycles: 1 APPLY, SETTLE × SETTLE-state, 1 CHECK.
- Y is sampled on the rising edge ending the CHECK cycle. The DUT therefore gets SETTLE + 1 full cycles of propagation time.
- Run timing:
  - START is sampled high at edge 0.
  - BUSY rises after edge 0.
  - DONE and PASS rise after edge 16 × (SETTLE + 2).
  - BUSY falls on that same edge.
- The new FAIL_MASK and FAIL_STEP are visible the cycle after the failing CHECK.

## Test plan
- Good DUT (Y = A & B, 1-cycle delay), SETTLE = 4, one START pulse:
  - BUSY is high for exactly 96 cycles.
  - Then DONE = 1, PASS = 1, FAIL_MASK = 0000.
- Y[2] stuck-at-1:
  - Mismatch at step 0 (gate 0, expected Y = 0001).
  - Result: FAIL_MASK = 0100, FAIL_STEP = 0, PASS = 0.
- Gate 2 modelled as OR (Y[1] = A[1] | B[1]):
  - First mismatch at step 5.
  - Result: FAIL_MASK = 0010, FAIL_STEP = 5, PASS = 0.
- DUT with 6-cycle output delay:
  - SETTLE = 4 → PASS = 0, FAIL_STEP = 0.
  - SETTLE = 8 → PASS = 1, after 160 busy cycles.
- CLR_n pulsed low at cycle 40 of a run:
  - A = B = 0 and BUSY = DONE = 0 with no clock edge.
  - A fresh START completes a full 96-cycle walk with correct results.
- START held high during a run has no effect.
- Fault run followed by START in FINISH, with the fault removed:
  - DONE clears after the START edge and the fail fields clear.
  - Second run ends with PASS = 1.
